// File: rtl/vga_textbuf_pkg.sv
// Shared constants and types for the VGA text-buffer RAM arbiter.
// The cursor-addressed CPU port is enabled with TEXTBUF_CURSOR_EN.
package vga_textbuf_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;
  localparam int CELLS    = DEF_COLS * DEF_ROWS;
  localparam int DEF_AW   = 12;
  localparam int DEF_DW   = 8;
  localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_DISP = 2'd1,
    G_CLR  = 2'd2,
    G_CPU  = 2'd3
  } grant_e;

  // Fixed priority: display, then clear engine, then CPU.
  function automatic grant_e pick_grant(input logic disp, input logic clr,
                                        input logic cpu);
    grant_e g;
    g = G_NONE;
    if (disp)     g = G_DISP;
    else if (clr) g = G_CLR;
    else if (cpu) g = G_CPU;
    return g;
  endfunction

endpackage

// File: rtl/vga_textbuf_clr_fsm.sv
// Full-screen clear engine: walks the cell counter once per granted cycle.
// State is exported on 'state' for observation.
module vga_textbuf_clr_fsm
  import vga_textbuf_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int NCELLS = CELLS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          grant,
  output logic          busy,
  output logic          done,
  output logic          wrap,
  output logic [AW-1:0] addr,
  output clr_state_e    state
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_CLEAR = CLEAR;

  logic [0:0]    st;
  logic [AW-1:0] cnt;

  assign busy  = (st == S_CLEAR);
  assign addr  = cnt;
  assign state = clr_state_e'(st);
  // Last cell is being issued this cycle; the FSM leaves CLEAR at this edge.
  assign wrap  = busy && grant && (cnt == AW'(NCELLS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= S_IDLE;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= wrap;
      case (st)
        S_IDLE: begin
          if (start) begin
            st  <= S_CLEAR;
            cnt <= '0;
          end
        end
        S_CLEAR: begin
          if (wrap) begin
            st  <= S_IDLE;
            cnt <= '0;
          end else if (grant) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_textbuf_arbiter.sv
// Single-port character RAM arbiter: display fetch > clear engine > CPU write.
// Define TEXTBUF_CURSOR_EN to address CPU writes from an internal cursor.
module vga_textbuf_arbiter
  import vga_textbuf_pkg::*;
#(
  parameter int             COLS       = DEF_COLS,
  parameter int             ROWS       = DEF_ROWS,
  parameter int             AW         = DEF_AW,
  parameter int             DW         = DEF_DW,
  parameter logic [DW-1:0]  BLANK_CHAR = BLANK_CHAR_DEF
) (
  input  logic          CLK,
  input  logic          RST_BTN,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
`ifdef TEXTBUF_CURSOR_EN
  output logic [AW-1:0] cursor_pos,
`endif
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int NCELLS = COLS * ROWS;

  // Handshake: a CPU write transfers on any cycle where cpu_valid && cpu_ready.
  // cpu_ready is combinational and only depends on disp_req and clr_busy.
  grant_e        grant;
  clr_state_e    clr_state;
  logic [AW-1:0] clr_addr;
  logic          clr_wrap;
  logic [AW-1:0] wr_addr;
  logic          wr_ok;
  logic          disp_p1;

  always_comb begin
    grant = pick_grant(disp_req, clr_state == CLEAR, cpu_valid);
  end

  assign cpu_ready = !disp_req && !clr_busy;
  assign disp_data = ram_rdata;
  // Out-of-range CPU writes still complete the handshake but never reach the RAM.
  assign wr_ok     = (wr_addr < AW'(NCELLS));

  vga_textbuf_clr_fsm #(
    .AW     (AW),
    .NCELLS (NCELLS)
  ) u_clr (
    .clk   (CLK),
    .rst   (RST_BTN),
    .start (clr_start),
    .grant (grant == G_CLR),
    .busy  (clr_busy),
    .done  (clr_done),
    .wrap  (clr_wrap),
    .addr  (clr_addr),
    .state (clr_state)
  );

`ifdef TEXTBUF_CURSOR_EN
  logic [AW-1:0] cursor;
  logic          unused_cpu_addr;

  assign unused_cpu_addr = ^cpu_addr;
  assign wr_addr         = cursor;
  assign cursor_pos      = cursor;

  // Cursor returns home at the edge that issues the last clear write.
  always_ff @(posedge CLK) begin
    if (RST_BTN || clr_wrap) begin
      cursor <= '0;
    end else if (grant == G_CPU) begin
      cursor <= (cursor == AW'(NCELLS - 1)) ? '0 : cursor + 1'b1;
    end
  end
`else
  logic unused_clr_wrap;

  assign unused_clr_wrap = clr_wrap;
  assign wr_addr         = cpu_addr;
`endif

  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      disp_p1    <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      // RAM sees the address one cycle after disp_req and returns data one later.
      disp_p1    <= disp_req;
      disp_valid <= disp_p1;
      case (grant)
        G_DISP: begin
          ram_addr <= disp_addr;
          ram_we   <= 1'b0;
        end
        G_CLR: begin
          ram_addr  <= clr_addr;
          ram_we    <= 1'b1;
          ram_wdata <= BLANK_CHAR;
        end
        G_CPU: begin
          ram_addr  <= wr_addr;
          ram_we    <= wr_ok;
          ram_wdata <= cpu_data;
        end
        default: begin
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_textbuf_arbiter.sv
// Directed bench for vga_textbuf_arbiter with a behavioural one-cycle-read RAM.
// Build with TEXTBUF_CURSOR_EN to exercise the cursor-addressed CPU port.
module tb_vga_textbuf_arbiter;

  localparam int NC = 2400;
  localparam logic [7:0] BLANK = 8'h20;

  logic        CLK;
  logic        RST_BTN;
  logic        disp_req;
  logic [11:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
`ifdef TEXTBUF_CURSOR_EN
  logic [11:0] cursor_pos;
  int          exp_cur = 0;
`endif

  logic [7:0]  mem     [0:4095];
  logic [7:0]  exp_mem [0:4095];
  logic [7:0]  exp_q[$];
  logic        fill_req  = 1'b0;
  int          fill_seed = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;

  vga_textbuf_arbiter dut (
    .CLK        (CLK),
    .RST_BTN    (RST_BTN),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
`ifdef TEXTBUF_CURSOR_EN
    .cursor_pos (cursor_pos),
`endif
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] pat(input int i, input int seed);
    return 8'((i * 7 + seed) & 255);
  endfunction

  // RAM model: read-first, one-cycle read latency; bench fill shares the port
  always @(posedge CLK) begin
    ram_rdata <= mem[ram_addr];
    if (fill_req) begin
      for (int i = 0; i < 4096; i++) mem[i] = pat(i, fill_seed);
    end else if (ram_we) begin
      mem[ram_addr] = ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard for display reads
  always @(negedge CLK) begin
    if (!RST_BTN && disp_valid) begin
      if (exp_q.size() == 0) begin
        check("disp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        pops++;
        check("disp_data", {24'd0, disp_data}, {24'd0, e});
      end
    end
  end

  // driver tasks (called and returning at a negedge)
  task automatic do_fill(input int seed);
    fill_seed = seed;
    fill_req  = 1'b1;
    @(negedge CLK);
    fill_req  = 1'b0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = pat(i, seed);
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  function automatic int next_tgt(input int addr);
`ifdef TEXTBUF_CURSOR_EN
    int t;
    t = exp_cur;
    exp_cur = (exp_cur + 1) % NC;
    return t;
`else
    return addr;
`endif
  endfunction

  task automatic drive_disp(input logic [11:0] a);
    disp_req  = 1'b1;
    disp_addr = a;
    exp_q.push_back(exp_mem[a]);
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d, input string tag);
    int tgt;
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_data  = d;
    #1;
    check({tag, "_ready"}, cpu_ready, 1);
    tgt = next_tgt(a);
    @(negedge CLK);
    cpu_valid = 1'b0;
    check({tag, "_we"}, ram_we, (tgt < NC));
    if (tgt < NC) begin
      check({tag, "_addr"}, ram_addr, tgt);
      check({tag, "_wdata"}, ram_wdata, d);
      exp_mem[tgt] = d;
    end
  endtask

  task automatic watch_clear(input bit with_disp, input int busy_init,
                             output int busy_n, output int slots,
                             output int dones, output int done_at_fall);
    int idle_n;
    int k;
    idle_n = 0;
    k = 0;
    busy_n = busy_init;
    slots = 0;
    dones = 0;
    done_at_fall = 0;
    while (idle_n < 3 && k < 6000) begin
      @(negedge CLK);
      k++;
      disp_req  = 1'b0;
      clr_start = 1'b0;
      if (clr_done) dones++;
      if (clr_busy) begin
        busy_n++;
        if (busy_n == 100) clr_start = 1'b1;
        if (with_disp && (k % 8 == 0)) begin
          drive_disp(12'($urandom_range(NC, 4095)));
          slots++;
        end
      end else begin
        if (idle_n == 0) done_at_fall = clr_done;
        idle_n++;
      end
    end
    disp_req  = 1'b0;
    clr_start = 1'b0;
    check("clear_terminated", (k < 6000), 1);
  endtask

  initial begin
    int busy_n, slots, dones, dfall, k, p0, tgt;
    RST_BTN   = 1'b1;
    disp_req  = 1'b0;
    disp_addr = '0;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    cpu_data  = '0;
    clr_start = 1'b0;

    // reset: 3 cycles, fill RAM so that cell 5 holds 8'h41
    @(negedge CLK);
    do_fill(30);
    @(negedge CLK);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_cpu_ready", cpu_ready, 1);
`ifdef TEXTBUF_CURSOR_EN
    check("rst_cursor", cursor_pos, 0);
`endif
    RST_BTN = 1'b0;

    // display read of cell 5 with latency checks
    @(negedge CLK);
    drive_disp(12'd5);
    @(negedge CLK);
    disp_req = 1'b0;
    check("disp_lat1_valid", disp_valid, 0);
    check("disp_lat1_addr", ram_addr, 5);
    @(negedge CLK);
    check("disp_lat2_valid", disp_valid, 1);
    check("disp_41", disp_data, 8'h41);
    @(negedge CLK);
    check("disp_lat3_valid", disp_valid, 0);

    // back-to-back display reads
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      drive_disp(12'($urandom_range(0, NC - 1)));
      @(negedge CLK);
    end
    disp_req = 1'b0;
    repeat (3) @(negedge CLK);
    check("b2b_pops", pops - p0, 4);

    // arbitration: display holds off the CPU
    cpu_valid = 1'b1;
    cpu_addr  = 12'd10;
    cpu_data  = 8'h42;
    for (int i = 0; i < 3; i++) begin
      drive_disp(12'($urandom_range(100, 200)));
      #1;
      check("arb_ready_low", cpu_ready, 0);
      @(negedge CLK);
      check("arb_no_write", ram_we, 0);
    end
    disp_req = 1'b0;
    cpu_write(12'd10, 8'h42, "arb");
    tgt = ram_addr;
    @(negedge CLK);
    check("arb_we_drop", ram_we, 0);
    drive_disp(12'(tgt));
    @(negedge CLK);
    disp_req = 1'b0;
    repeat (3) @(negedge CLK);

    // out-of-range CPU write
    cpu_write(12'd2400, 8'hEE, "oor");
    repeat (2) @(negedge CLK);
    cmp_mem("oor_ram");

    // clear started together with a CPU write; clr_start pulsed again mid-clear
    clr_start = 1'b1;
    cpu_valid = 1'b1;
    cpu_addr  = 12'd20;
    cpu_data  = 8'h77;
    #1;
    check("clrcpu_ready", cpu_ready, 1);
    tgt = next_tgt(20);
    @(negedge CLK);
    clr_start = 1'b0;
    cpu_valid = 1'b0;
    check("clrcpu_we", ram_we, 1);
    check("clrcpu_addr", ram_addr, tgt);
    check("clrcpu_busy", clr_busy, 1);
    watch_clear(1'b0, 1, busy_n, slots, dones, dfall);
    check("clr1_busy_cycles", busy_n, NC);
    check("clr1_done_pulses", dones, 1);
    check("clr1_done_at_fall", dfall, 1);
    for (int i = 0; i < NC; i++) exp_mem[i] = BLANK;
`ifdef TEXTBUF_CURSOR_EN
    exp_cur = 0;
    check("clr1_cursor_home", cursor_pos, 0);
`endif
    cmp_mem("clr1_ram");

    // clear with a display fetch every 8th cycle
    do_fill(50);
    clr_start = 1'b1;
    watch_clear(1'b1, 0, busy_n, slots, dones, dfall);
    check("clr2_busy_cycles", busy_n, NC + slots);
    check("clr2_done_pulses", dones, 1);
    for (int i = 0; i < NC; i++) exp_mem[i] = BLANK;
    cmp_mem("clr2_ram");

    // reset at clear counter 1000
    do_fill(99);
    clr_start = 1'b1;
    @(negedge CLK);
    clr_start = 1'b0;
    busy_n = 0;
    dones = 0;
    k = 0;
    while (k < 3000) begin
      if (clr_busy) busy_n++;
      if (clr_done) dones++;
      if (busy_n == 1001) break;
      @(negedge CLK);
      k++;
    end
    check("abort_reached", busy_n, 1001);
    RST_BTN = 1'b1;
    @(negedge CLK);
    check("abort_busy", clr_busy, 0);
    check("abort_done", clr_done, 0);
    check("abort_we", ram_we, 0);
    RST_BTN = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (clr_done) dones++;
    end
    check("abort_no_done", dones, 0);
    for (int i = 0; i < 1000; i++) exp_mem[i] = BLANK;
    cmp_mem("abort_ram");

`ifdef TEXTBUF_CURSOR_EN
    // 2401 back-to-back cursor writes wrap once
    exp_cur = 0;
    check("cur_start", cursor_pos, 0);
    cpu_valid = 1'b1;
    for (int i = 0; i < 2401; i++) begin
      cpu_addr = 12'($urandom_range(0, 4095));
      cpu_data = 8'($urandom_range(0, 255));
      exp_mem[exp_cur] = cpu_data;
      exp_cur = (exp_cur + 1) % NC;
      @(negedge CLK);
    end
    cpu_valid = 1'b0;
    check("cur_wrap", cursor_pos, exp_cur);
    check("cur_is_one", cursor_pos, 1);
    repeat (2) @(negedge CLK);
    cmp_mem("cur_ram");
`endif

    repeat (3) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
